// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM server giving ULA fetches fixed latency and slotting Z80 accesses into the gaps.
// Define VRAM_PAGE7_EN to drive sram_a[14] from ula_page/cpu_bank7 (32 KB store); otherwise it is tied to 0.
module vram_arbiter #(
  parameter int VADDR_W = 14
) (
  input  logic               clk28,
  input  logic               rst,
  input  logic               ula_vreq,
  input  logic [VADDR_W-1:0] va,
  input  logic               ula_page,
  output logic [7:0]         vramdata,
  input  logic [15:0]        a,
  input  logic               mreq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               cpu_bank7,
  input  logic [7:0]         din,
  output logic [7:0]         cpu_dout,
  output logic               cpu_vram_sel,
  output logic               cpu_wait_n,
  output logic [VADDR_W:0]   sram_a,
  input  logic [7:0]         sram_din,
  output logic [7:0]         sram_dout,
  output logic               sram_dout_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);
  typedef enum logic [2:0] {IDLE, V1, V2, C1, C2} state_t;
  state_t st;
  logic pending, taken, rd, lat_bank, vpage, cbank, capture;
  logic [VADDR_W-1:0] lat_a;
  logic [7:0] lat_d;
`ifdef VRAM_PAGE7_EN
  assign vpage = ula_page;
  assign cbank = cpu_bank7;
`else
  logic unused_page;
  assign vpage = 1'b0;
  assign cbank = 1'b0;
  assign unused_page = ula_page ^ cpu_bank7;
`endif
  assign capture = !mreq_n && a[15:14] == 2'b01 && (!rd_n || !wr_n) && !taken;
  assign cpu_vram_sel = !mreq_n && !rd_n && a[15:14] == 2'b01;
  assign cpu_wait_n = !pending;
  // taken blocks re-capture until mreq_n goes high: one service per machine cycle
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      pending <= 1'b0;
      taken <= 1'b0;
      rd <= 1'b1;
      lat_bank <= 1'b0;
      lat_a <= '0;
      lat_d <= 8'h00;
      vramdata <= 8'h00;
      cpu_dout <= 8'hff;
      sram_a <= '0;
      sram_dout <= 8'h00;
      sram_dout_oe <= 1'b0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
    end else begin
      if (mreq_n) taken <= 1'b0;
      else if (capture) taken <= 1'b1;
      if (capture) begin
        lat_a <= a[VADDR_W-1:0];
        lat_d <= din;
        rd <= wr_n;
        lat_bank <= cbank;
      end
      if (capture) pending <= 1'b1;
      else if (st == C2) pending <= 1'b0;
      case (st)
        IDLE, V2: begin
          if (st == V2) vramdata <= sram_din;
          if (ula_vreq) begin
            st <= V1;
            sram_a <= {vpage, va};
            sram_oe_n <= 1'b0;
            sram_dout_oe <= 1'b0;
          end else if (pending) begin
            st <= C1;
            sram_a <= {lat_bank, lat_a};
            sram_oe_n <= !rd;
            sram_dout_oe <= !rd;
            if (!rd) sram_dout <= lat_d;
          end else begin
            st <= IDLE;
            sram_oe_n <= 1'b1;
            sram_dout_oe <= 1'b0;
          end
        end
        V1: st <= V2;
        C1: begin
          st <= C2;
          sram_we_n <= rd;
        end
        C2: begin
          st <= IDLE;
          sram_we_n <= 1'b1;
          sram_oe_n <= 1'b1;
          if (rd) cpu_dout <= sram_din;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
